// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one memory port between the instruction fetch unit
//                and the load/store unit. One transaction in flight; LSU has
//                fixed priority, bounded by a streak limiter so the IFU is
//                never starved.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int MAX_LSU_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  // instruction fetch side
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  // load/store side
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  // memory side
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int         c_MASK_W     = DATA_W / 8;
  localparam logic [3:0] c_STREAK_MAX = 4'(MAX_LSU_STREAK);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_owner_lsu;
  logic [3:0]          r_streak;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wen;
  logic [DATA_W-1:0]   r_wdata;
  logic [c_MASK_W-1:0] r_wmask;
  logic [DATA_W-1:0]   r_rdata;
  logic                w_grant_lsu;
  logic                w_grant_ifu;
  logic                w_streak_full;

  assign w_streak_full = (r_streak == c_STREAK_MAX);

  // Arbitration in IDLE and next-state selection; grants are masked while
  // reset is high so no ready escapes during an asynchronous reset.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_lsu = 1'b0;
    w_grant_ifu = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!rst) begin
          if (lsu_req_valid && !(ifu_req_valid && w_streak_full)) begin
            w_grant_lsu = 1'b1;
          end else if (ifu_req_valid) begin
            w_grant_ifu = 1'b1;
          end
        end
        if (w_grant_lsu || w_grant_ifu) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: if (mem_req_ready) w_state_nxt = S_WAIT;
      S_WAIT:  if (mem_rsp_valid) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request latch, owner and LSU streak tracking on the accept edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner_lsu <= 1'b0;
      r_streak    <= 4'd0;
      r_addr      <= '0;
      r_wen       <= 1'b0;
      r_wdata     <= '0;
      r_wmask     <= '0;
    end else if (w_grant_lsu) begin
      r_owner_lsu <= 1'b1;
      r_addr      <= lsu_addr;
      r_wen       <= lsu_wen;
      r_wdata     <= lsu_wdata;
      r_wmask     <= lsu_wmask;
      if (ifu_req_valid && (r_streak < c_STREAK_MAX)) begin
        r_streak <= r_streak + 4'd1;
      end
    end else if (w_grant_ifu) begin
      r_owner_lsu <= 1'b0;
      r_streak    <= 4'd0;
      r_addr      <= ifu_addr;
      r_wen       <= 1'b0;
      r_wdata     <= '0;
      r_wmask     <= '0;
    end
  end

  // Response capture; only a response while waiting is meaningful
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if ((r_state == S_WAIT) && mem_rsp_valid) begin
      r_rdata <= mem_rdata;
    end
  end

  assign ifu_req_ready = w_grant_ifu;
  assign lsu_req_ready = w_grant_lsu;
  assign mem_req_valid = (r_state == S_ISSUE);
  assign mem_addr      = r_addr;
  assign mem_wen       = r_wen;
  assign mem_wdata     = r_wdata;
  assign mem_wmask     = r_wmask;
  assign ifu_rsp_valid = (r_state == S_RESP) && !r_owner_lsu;
  assign lsu_rsp_valid = (r_state == S_RESP) &&  r_owner_lsu;
  assign ifu_rdata     = r_rdata;
  assign lsu_rdata     = r_rdata;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Sequences and shares the single physical memory port between the instruction fetch unit (IFU) and the load/store unit (LSU).
- Accepts one request at a time and forwards it to memory with a valid/ready handshake.
- Waits for the memory response, then returns registered read data to the requester that owns the transaction.
- LSU has fixed priority; a streak limiter prevents IFU starvation.

Parameters:
ADDR_W, 64, address width of all address ports
DATA_W, 64, data width; wmask width is DATA_W/8
MAX_LSU_STREAK, 4, consecutive LSU grants allowed while IFU is waiting; legal range 1..15

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, asynchronous, active-high
ifu_req_valid  in  1  IFU fetch request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_addr  in  ADDR_W  fetch address
ifu_rsp_valid  out  1  one-cycle pulse: ifu_rdata is valid
ifu_rdata  out  DATA_W  fetch data
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_addr  in  ADDR_W  data address
lsu_wen  in  1  1 = write, 0 = read
lsu_wdata  in  DATA_W  write data
lsu_wmask  in  DATA_W/8  byte enables
lsu_rsp_valid  out  1  one-cycle pulse: read data valid / write complete
lsu_rdata  out  DATA_W  load data
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  memory address
mem_wen  out  1  memory write enable
mem_wdata  out  DATA_W  memory write data
mem_wmask  out  DATA_W/8  memory byte enables
mem_rsp_valid  in  1  memory response (one-cycle pulse)
mem_rdata  in  DATA_W  memory read data

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. At most one transaction is outstanding.
- Reset (async, any state): FSM goes to IDLE, owner=IFU, streak=0. All valid/ready outputs are 0; mem_addr, mem_wdata, mem_wmask, mem_wen and rdata_q are 0. Any in-flight transaction is discarded. A mem_rsp_valid that arrives after reset is ignored, because it can only land in IDLE.
- IDLE arbitration (combinational ready):
  - Only lsu valid: lsu_req_ready=1.
  - Only ifu valid: ifu_req_ready=1.
  - Both valid: grant IFU if streak==MAX_LSU_STREAK, else grant LSU.
  - Neither valid: no ready asserted.
  - On the accept edge: latch addr/wen/wdata/wmask (IFU forces wen=0, wmask=0, wdata=0), set owner, go to ISSUE.
  - Ready is never asserted outside IDLE and never to both requesters at once.
- Streak counter:
  - Increments on an LSU grant while ifu_req_valid=1.
  - Clears on any IFU grant.
  - Holds on an LSU grant while IFU is idle.
  - Saturates at MAX_LSU_STREAK.
- ISSUE: mem_req_valid=1, mem_* driven from the latched registers and held stable until mem_req_ready. On mem_req_valid&&mem_req_ready, go to WAIT. Requester inputs are ignored.
- WAIT: on mem_rsp_valid, capture mem_rdata into rdata_q (writes also capture) and go to RESP.
- RESP: pulse the owner's rsp_valid for exactly 1 cycle, then go to IDLE.
- Read data: ifu_rdata and lsu_rdata both equal rdata_q and hold their value until the next capture.
- mem_rsp_valid in IDLE, ISSUE or RESP is ignored: no state change, no capture.
- Latency from accept at edge t:
  - mem_req_valid is high during cycle t+1.
  - With zero-wait memory (ready at t+1, response at t+2), rsp_valid is high in cycle t+3.
  - Minimum request-to-request spacing is 4 cycles.
- Widths: no arithmetic on addresses or data; all pass-through at full width.

Test Plan:
- Single IFU fetch: ifu_addr=0x80000000, memory ready immediately, response 0x00000413_00100073 one cycle later -> mem_addr=0x80000000 and mem_wen=0 in cycle t+1; ifu_rsp_valid for 1 cycle at t+3 with ifu_rdata=0x0000041300100073; lsu_rsp_valid stays 0.
- LSU write with backpressure: lsu_wen=1, addr=0x80001000, wdata=0xDEADBEEF, wmask=0x0F, mem_req_ready held low 3 cycles -> mem_* stable across all 4 ISSUE cycles; lsu_rsp_valid pulses after mem_rsp_valid; ifu_req_ready=0 throughout.
- Priority and starvation: both requesters continuously valid, MAX_LSU_STREAK=4 -> grant order LSU,LSU,LSU,LSU,IFU,LSU,LSU,LSU,LSU,IFU; never two readies in the same cycle.
- Spurious response: mem_rsp_valid pulsed in IDLE with mem_rdata=0x1234 -> no rsp_valid pulse; rdata_q keeps its prior value; state stays IDLE.
- Reset mid-transaction: assert rst asynchronously during WAIT -> all valid/ready outputs drop to 0 before the next clock edge; a later mem_rsp_valid produces no rsp pulse; after rst deasserts, a new IFU request completes normally.
- Ready only in IDLE: hold ifu_req_valid=1 during an LSU transaction -> ifu_req_ready=0 in ISSUE, WAIT and RESP; IFU is accepted in the first IDLE cycle after RESP.
